// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port, fixed-latency memory between the instruction-fetch
// (IF) and load/store (LS) requesters of the unified-memory core variant.
// LS has fixed priority. An anti-starvation counter forces an IF grant after
// STARVE_MAX consecutive LS grants made while IF was waiting.
// Only one transaction is in flight at a time.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   if_req/if_addr                  IF read request and address
//   if_gnt/if_rvalid/if_rdata       IF accept, data-valid pulse, read data
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_be                  LS request (load or store)
//   ls_gnt/ls_rvalid/ls_rdata       LS accept, completion pulse, load data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_be/mem_rdata      memory macro interface
//   busy                            transaction in flight
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,

  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy
);

  localparam int LAT_W = 3;
  localparam int STV_W = 4;

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;

  state_e           state_q;
  owner_e           owner_q;
  logic             we_q;       // in-flight LS access is a store
  logic [LAT_W-1:0] lat_cnt_q;
  logic [STV_W-1:0] starve_cnt_q;

  logic lat_done;
  logic done;
  logic free;
  logic force_if;
  logic ls_win;
  logic if_win;

  assign lat_done = (lat_cnt_q == LAT_W'(MEM_LAT));
  // Outputs are qualified with rst_n so they read 0 for the whole time reset
  // is held, even if a requester keeps its req asserted.
  assign done     = rst_n && (state_q == BUSY) && lat_done;
  assign free     = rst_n && ((state_q == IDLE) || lat_done);
  assign force_if = if_req && (starve_cnt_q == STV_W'(STARVE_MAX));
  assign ls_win   = free && ls_req && !force_if;
  assign if_win   = free && if_req && !ls_win;

  assign if_gnt = if_win;
  assign ls_gnt = ls_win;
  assign busy   = (state_q == BUSY);

  assign if_rvalid = done && (owner_q == OWN_IF);
  assign ls_rvalid = done && (owner_q == OWN_LS);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = (ls_rvalid && !we_q) ? mem_rdata : '0;

  // Memory strobe and steering for the winner of this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (ls_win) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_be    = ls_be;
    end else if (if_win) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      mem_be    = '1;
    end
  end

  // Transaction state and anti-starvation counter.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      if (ls_win || if_win) begin
        // A new grant on the completion cycle chains straight into the next access.
        state_q   <= BUSY;
        owner_q   <= ls_win ? OWN_LS : OWN_IF;
        we_q      <= ls_win && ls_we;
        lat_cnt_q <= LAT_W'(1);
      end else if (state_q == BUSY) begin
        if (lat_done) begin
          state_q   <= IDLE;
          lat_cnt_q <= '0;
        end else begin
          lat_cnt_q <= lat_cnt_q + LAT_W'(1);
        end
      end

      // Counts LS grants taken while IF waits; cleared once IF is served or idle.
      if (!if_req || if_win) begin
        starve_cnt_q <= '0;
      end else if (ls_win && (starve_cnt_q != STV_W'(STARVE_MAX))) begin
        starve_cnt_q <= starve_cnt_q + STV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Directed bench. Three arbiter instances share all inputs and differ only in
// MEM_LAT (1, 2, 3); each scenario resets all three and observes the instance
// whose latency it targets. Inputs change 1 ns after the rising edge and
// outputs are sampled 1 ns later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic [31:0] mem_rdata;

  logic        if_gnt    [3];
  logic        if_rvalid [3];
  logic [31:0] if_rdata  [3];
  logic        ls_gnt    [3];
  logic        ls_rvalid [3];
  logic [31:0] ls_rdata  [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [3:0]  mem_be    [3];
  logic        busy      [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    unified_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1), .STARVE_MAX(4)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt[g]),
      .if_rvalid (if_rvalid[g]),
      .if_rdata  (if_rdata[g]),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_be     (ls_be),
      .ls_gnt    (ls_gnt[g]),
      .ls_rvalid (ls_rvalid[g]),
      .ls_rdata  (ls_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_be    (mem_be[g]),
      .mem_rdata (mem_rdata),
      .busy      (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    ls_req    = 1'b0;
    ls_we     = 1'b0;
    ls_addr   = '0;
    ls_wdata  = '0;
    ls_be     = '0;
    mem_rdata = '0;
  endtask

  // Pulse reset; returns 1 ns after a rising edge with every instance IDLE.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    if_req = 1'b1;           // requests held during reset must not be granted
    ls_req = 1'b1;
    #3;
    check("rst_if_gnt",    32'(if_gnt[0]),    0);
    check("rst_ls_gnt",    32'(ls_gnt[0]),    0);
    check("rst_mem_en",    32'(mem_en[0]),    0);
    check("rst_mem_be",    32'(mem_be[0]),    0);
    check("rst_busy",      32'(busy[0]),      0);
    check("rst_if_rvalid", 32'(if_rvalid[0]), 0);

    // ---- 1: MEM_LAT=1, IF-only streaming -----------------------------------
    do_reset();
    if_req = 1'b1; if_addr = 32'h0; #1;
    check("t1_gnt0",  32'(if_gnt[0]),   1);
    check("t1_en0",   32'(mem_en[0]),   1);
    check("t1_addr0", mem_addr[0],      32'h0);
    check("t1_be0",   32'(mem_be[0]),   32'hF);
    check("t1_we0",   32'(mem_we[0]),   0);
    check("t1_busy0", 32'(busy[0]),     0);
    cyc(); if_addr = 32'h4; mem_rdata = 32'h1111_0000; #1;
    check("t1_rv1",   32'(if_rvalid[0]), 1);
    check("t1_rd1",   if_rdata[0],       32'h1111_0000);
    check("t1_gnt1",  32'(if_gnt[0]),    1);
    check("t1_addr1", mem_addr[0],       32'h4);
    check("t1_busy1", 32'(busy[0]),      1);
    cyc(); if_addr = 32'h8; mem_rdata = 32'h2222_0004; #1;
    check("t1_rv2",   32'(if_rvalid[0]), 1);
    check("t1_rd2",   if_rdata[0],       32'h2222_0004);
    check("t1_addr2", mem_addr[0],       32'h8);
    check("t1_busy2", 32'(busy[0]),      1);
    cyc(); if_req = 1'b0; mem_rdata = 32'h3333_0008; #1;
    check("t1_rv3",   32'(if_rvalid[0]), 1);
    check("t1_rd3",   if_rdata[0],       32'h3333_0008);
    check("t1_gnt3",  32'(if_gnt[0]),    0);
    check("t1_en3",   32'(mem_en[0]),    0);
    check("t1_maddr3", mem_addr[0],      32'h0);
    cyc(); #1;
    check("t1_busy4", 32'(busy[0]),      0);
    check("t1_rv4",   32'(if_rvalid[0]), 0);
    check("t1_rd4",   if_rdata[0],       32'h0);

    // ---- 2: MEM_LAT=2, simultaneous IF + LS load ---------------------------
    do_reset();
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; #1;
    check("t2_ls_gnt0", 32'(ls_gnt[1]),  1);
    check("t2_if_gnt0", 32'(if_gnt[1]),  0);
    check("t2_addr0",   mem_addr[1],     32'h100);
    check("t2_we0",     32'(mem_we[1]),  0);
    cyc(); ls_req = 1'b0; #1;
    check("t2_if_gnt1", 32'(if_gnt[1]),  0);
    check("t2_en1",     32'(mem_en[1]),  0);
    cyc(); mem_rdata = 32'hA5A5_0100; #1;
    check("t2_ls_rv2",  32'(ls_rvalid[1]), 1);
    check("t2_ls_rd2",  ls_rdata[1],       32'hA5A5_0100);
    check("t2_if_rv2",  32'(if_rvalid[1]), 0);
    check("t2_if_gnt2", 32'(if_gnt[1]),    1);
    check("t2_addr2",   mem_addr[1],       32'h40);
    cyc(); if_req = 1'b0; mem_rdata = 32'h0; #1;
    check("t2_if_rv3",  32'(if_rvalid[1]), 0);
    check("t2_busy3",   32'(busy[1]),      1);
    cyc(); mem_rdata = 32'h5A5A_0040; #1;
    check("t2_if_rv4",  32'(if_rvalid[1]), 1);
    check("t2_if_rd4",  if_rdata[1],       32'h5A5A_0040);
    check("t2_ls_rv4",  32'(ls_rvalid[1]), 0);
    check("t2_ls_rd4",  ls_rdata[1],       32'h0);

    // ---- 3: starvation bound, MEM_LAT=1, STARVE_MAX=4 ----------------------
    do_reset();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h300; #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_ls_gnt%0d", i), 32'(ls_gnt[0]), (i % 5 == 4) ? 0 : 1);
      check($sformatf("t3_if_gnt%0d", i), 32'(if_gnt[0]), (i % 5 == 4) ? 1 : 0);
      check($sformatf("t3_addr%0d", i),   mem_addr[0],
            (i % 5 == 4) ? 32'h300 : 32'h200);
      cyc(); #1;
    end

    // ---- 4: store, MEM_LAT=1 -----------------------------------------------
    do_reset();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20;
    ls_wdata = 32'hDEAD_BEEF; ls_be = 4'hF; #1;
    check("t4_gnt",   32'(ls_gnt[0]),  1);
    check("t4_en",    32'(mem_en[0]),  1);
    check("t4_we",    32'(mem_we[0]),  1);
    check("t4_addr",  mem_addr[0],     32'h20);
    check("t4_wdata", mem_wdata[0],    32'hDEAD_BEEF);
    check("t4_be",    32'(mem_be[0]),  32'hF);
    cyc(); ls_req = 1'b0; ls_we = 1'b0; mem_rdata = 32'h1234_5678; #1;
    check("t4_rv",    32'(ls_rvalid[0]), 1);
    check("t4_rd",    ls_rdata[0],       32'h0);
    check("t4_en1",   32'(mem_en[0]),    0);

    // ---- 5: reset mid-transaction, MEM_LAT=3 -------------------------------
    do_reset();
    if_req = 1'b1; if_addr = 32'h80; #1;
    check("t5_gnt", 32'(if_gnt[2]), 1);
    cyc(); if_req = 1'b0; #1;
    cyc(); mem_rdata = 32'hFFFF_FFFF; #1;     // lat_cnt==2 here
    check("t5_busy_pre", 32'(busy[2]), 1);
    rst_n = 1'b0; #1;
    check("t5_rst_busy", 32'(busy[2]),      0);
    check("t5_rst_rv",   32'(if_rvalid[2]), 0);
    check("t5_rst_rd",   if_rdata[2],       32'h0);
    check("t5_rst_en",   32'(mem_en[2]),    0);
    check("t5_rst_gnt",  32'(if_gnt[2]),    0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      check($sformatf("t5_post_rv%0d", i),   32'(if_rvalid[2]), 0);
      check($sformatf("t5_post_busy%0d", i), 32'(busy[2]),      0);
    end

    // ---- 6: LS pulse while BUSY is ignored, MEM_LAT=3 ----------------------
    do_reset();
    if_req = 1'b1; if_addr = 32'hC0; #1;
    check("t6_if_gnt", 32'(if_gnt[2]), 1);
    cyc(); if_req = 1'b0; ls_req = 1'b1; ls_addr = 32'h400; #1;
    check("t6_ls_gnt1", 32'(ls_gnt[2]), 0);
    check("t6_en1",     32'(mem_en[2]), 0);
    cyc(); ls_req = 1'b0; #1;
    check("t6_ls_gnt2", 32'(ls_gnt[2]), 0);
    check("t6_en2",     32'(mem_en[2]), 0);
    cyc(); mem_rdata = 32'h0000_C0C0; #1;
    check("t6_if_rv3",  32'(if_rvalid[2]), 1);
    check("t6_if_rd3",  if_rdata[2],       32'h0000_C0C0);
    check("t6_ls_gnt3", 32'(ls_gnt[2]),    0);
    check("t6_en3",     32'(mem_en[2]),    0);
    cyc(); #1;
    check("t6_busy4",   32'(busy[2]),      0);
    check("t6_ls_rv4",  32'(ls_rvalid[2]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
